// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state type, default watchdog limit and counter sizing for dmem_bridge
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} dmem_state_t;
  localparam int TIMEOUT_DEFAULT = 16;
  function automatic int cnt_width(input int t);
    return $clog2(t);
  endfunction
endpackage

// File: rtl/dmem_timeout.sv
// dmem_timeout: clearable, enabled cycle counter flagging TIMEOUT-1 as terminal count
module dmem_timeout import dmem_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = cnt_width(TIMEOUT);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (!reset_n || clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign tc = cnt == CW'(TIMEOUT - 1);
endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: MEM-stage data port to valid/ready RAM with watchdog; DMEM_ALIGN_CHECK_EN traps misaligned addresses
module dmem_bridge import dmem_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        d_req,
  input  logic [31:0] d_address,
  input  logic [31:0] d_data_write,
  input  logic        d_write_enable,
  output logic [31:0] d_data_read,
  output logic        d_data_valid,
  output logic        d_busy,
  output logic        d_error,
  output logic        m_valid,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_we,
  input  logic        m_ready,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata
);
  dmem_state_t state;
  logic err, tc, mis;
`ifdef DMEM_ALIGN_CHECK_EN
  assign mis = |d_address[1:0];
`else
  assign mis = 1'b0;
`endif
  dmem_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk(clk),
    .reset_n(reset_n),
    .clr(state == IDLE),
    .en(state == REQ || state == WAIT),
    .tc(tc)
  );
  // a response arriving on the terminal-count cycle takes priority over the abort
  always_ff @(posedge clk)
    if (!reset_n) begin
      state       <= IDLE;
      m_addr      <= '0;
      m_wdata     <= '0;
      m_we        <= 1'b0;
      d_data_read <= '0;
      err         <= 1'b0;
    end else begin
      case (state)
        IDLE: if (d_req) begin
          m_addr  <= d_address;
          m_wdata <= d_data_write;
          m_we    <= d_write_enable;
          err     <= mis;
          state   <= mis ? DONE : REQ;
          if (mis) d_data_read <= '0;
        end
        REQ: if (m_ready && m_rvalid) begin
          d_data_read <= m_we ? '0 : m_rdata;
          err         <= 1'b0;
          state       <= DONE;
        end else if (tc) begin
          d_data_read <= '0;
          err         <= 1'b1;
          state       <= DONE;
        end else if (m_ready) state <= WAIT;
        WAIT: if (m_rvalid) begin
          d_data_read <= m_we ? '0 : m_rdata;
          err         <= 1'b0;
          state       <= DONE;
        end else if (tc) begin
          d_data_read <= '0;
          err         <= 1'b1;
          state       <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  assign d_busy       = state != IDLE;
  assign m_valid      = state == REQ;
  assign d_data_valid = state == DONE;
  assign d_error      = state == DONE && err;
endmodule
